// File: rtl/lp805x_sched_pkg.sv
// Shared constants for the lp805x prescaler-index scheduler: default table,
// selection modes and FSM state encoding.
package lp805x_sched_pkg;

  // Entry 0 sits in the low bits; thresholds ascend with the index.
  localparam logic [71:0] SCHED_INIT_DEFAULT = {9'd511, 9'd500, 9'd250, 9'd125,
                                                9'd62,  9'd31,  9'd15,  9'd7};

  localparam logic SCHED_FIRST = 1'b0;
  localparam logic SCHED_BEST  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/lp805x_sched_tbl.sv
// Threshold register file: loads INIT on reset, accepts a write only when the
// scheduler allows it and the address exists, reads combinationally.
module lp805x_sched_tbl
  import lp805x_sched_pkg::*;
#(
  parameter int FW    = 9,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH),
  parameter logic [DEPTH*FW-1:0] INIT = (DEPTH*FW)'(SCHED_INIT_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          allow,
  input  logic [IW-1:0] waddr,
  input  logic [FW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [FW-1:0] rdata,
  output logic          wr_err
);

  logic [FW-1:0] mem [DEPTH];
  logic          ok;

  // Non-power-of-two depths leave unused addresses that must be rejected.
  assign ok    = allow && (int'(waddr) < DEPTH);
  assign rdata = mem[raddr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= INIT[k*FW +: FW];
      wr_err <= 1'b0;
    end else begin
      wr_err <= we && !ok;
      if (we && ok) mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/lp805x_schedfs_gen.sv
// Prescaler-index scheduler: scans the threshold table one entry per clock and
// reports the first-fit or best-fit index, with done/busy/nofit status.
module lp805x_schedfs_gen
  import lp805x_sched_pkg::*;
#(
  parameter int FW    = 9,
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH),
  parameter logic [DEPTH*FW-1:0] INIT = (DEPTH*FW)'(SCHED_INIT_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [FW-1:0] factor,
  input  logic          mode,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_addr,
  input  logic [FW-1:0] tbl_data,
  output logic [IW-1:0] index,
  output logic          done,
  output logic          busy,
  output logic          nofit,
  output logic          wr_err
);

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  sched_state_e  state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, bidx_q, bidx_d, index_d;
  logic [FW-1:0] f_q, f_d, bthr_q, bthr_d, thr;
  logic          m_q, m_d, bval_q, bval_d, nofit_d, done_d, hit;

  lp805x_sched_tbl #(.FW(FW), .DEPTH(DEPTH), .IW(IW), .INIT(INIT)) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .we     (tbl_we),
    .allow  (state_q == ST_IDLE),
    .waddr  (tbl_addr),
    .wdata  (tbl_data),
    .raddr  (ptr_q),
    .rdata  (thr),
    .wr_err (wr_err)
  );

  assign hit  = (f_q <= thr);
  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      f_q     <= '0;
      m_q     <= SCHED_FIRST;
      bidx_q  <= '0;
      bthr_q  <= '0;
      bval_q  <= 1'b0;
      index   <= '0;
      nofit   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      f_q     <= f_d;
      m_q     <= m_d;
      bidx_q  <= bidx_d;
      bthr_q  <= bthr_d;
      bval_q  <= bval_d;
      index   <= index_d;
      nofit   <= nofit_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    f_d     = f_q;
    m_d     = m_q;
    bidx_d  = bidx_q;
    bthr_d  = bthr_q;
    bval_d  = bval_q;
    index_d = index;
    nofit_d = nofit;
    done_d  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        // Strict less-than keeps the lower index on equal thresholds.
        if (hit && (!bval_q || thr < bthr_q)) begin
          bidx_d = ptr_q;
          bthr_d = thr;
          bval_d = 1'b1;
        end
        if ((hit && m_q == SCHED_FIRST) || ptr_q == LAST) state_d = ST_FIN;
        else ptr_d = ptr_q + IW'(1);
      end
      ST_FIN: begin
        index_d = bval_q ? bidx_q : LAST;
        nofit_d = !bval_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A start in any state (re)launches a scan and drops any partial result.
    if (start) begin
      state_d = ST_SCAN;
      f_d     = factor;
      m_d     = mode;
      ptr_d   = '0;
      bval_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_lp805x_schedfs_gen.sv
// Directed bench for lp805x_schedfs_gen: a vector table on the default
// thresholds plus hand sequences for writes, restarts, FIN-start and reset.
module tb_lp805x_schedfs_gen;
  import lp805x_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode, tbl_we;
  logic [9:0] factor, tbl_data;
  logic [2:0] tbl_addr, index;
  logic       done, busy, nofit, wr_err;

  logic       start6, mode6, we6;
  logic [8:0] factor6, data6;
  logic [2:0] addr6, index6;
  logic       done6, busy6, nofit6, wrerr6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Main instance is 10 bits wide so factors above the largest threshold exist.
  lp805x_schedfs_gen #(
    .FW(10), .DEPTH(8),
    .INIT({10'd511, 10'd500, 10'd250, 10'd125, 10'd62, 10'd31, 10'd15, 10'd7})
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .factor(factor), .mode(mode),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .index(index), .done(done), .busy(busy), .nofit(nofit), .wr_err(wr_err)
  );

  lp805x_schedfs_gen #(.FW(9), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst_n), .start(start6), .factor(factor6), .mode(mode6),
    .tbl_we(we6), .tbl_addr(addr6), .tbl_data(data6),
    .index(index6), .done(done6), .busy(busy6), .nofit(nofit6), .wr_err(wrerr6)
  );

  typedef struct {
    logic [9:0] f;
    logic       m;
    int         idx;
    int         nf;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [9:0] f, input logic m);
    @(negedge clk);
    factor = f; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit bok);
    lat = 0;
    bok = busy;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) bok = 1'b0;
    end
  endtask

  task automatic run_req(input string nm, input logic [9:0] f, input logic m,
                         input int ei, input int en, input int el);
    int lat;
    bit bok;
    issue(f, m);
    wait_done(lat, bok);
    chk({nm, ".lat"}, lat, el);
    chk({nm, ".index"}, int'(index), ei);
    chk({nm, ".nofit"}, int'(nofit), en);
    chk({nm, ".busy_during"}, int'(bok), 1);
    chk({nm, ".busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    chk({nm, ".done_width"}, int'(done), 0);
  endtask

  task automatic wr(input string nm, input logic [2:0] a, input logic [9:0] d, input int ee);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    chk(nm, int'(wr_err), ee);
  endtask

  task automatic restart_seq(input string nm, input logic [9:0] f1, input logic m1,
                             input logic [9:0] f2, input logic m2, input int ei, input int el);
    int dones = 0;
    int lat = 0;
    issue(f1, m1);
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    issue(f2, m2);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (lat == 0) lat = n;
      end
    end
    chk({nm, ".dones"}, dones, 1);
    chk({nm, ".lat"}, lat, el);
    chk({nm, ".index"}, int'(index), ei);
  endtask

  task automatic wr6(input string nm, input logic [2:0] a, input logic [8:0] d, input int ee);
    @(negedge clk);
    we6 = 1'b1; addr6 = a; data6 = d;
    @(posedge clk); #1;
    we6 = 1'b0;
    chk(nm, int'(wrerr6), ee);
  endtask

  task automatic run6(input string nm, input logic [8:0] f, input logic m,
                      input int ei, input int en, input int el);
    int lat = 0;
    @(negedge clk);
    factor6 = f; mode6 = m; start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done6) begin
        lat = n;
        break;
      end
    end
    chk({nm, ".lat"}, lat, el);
    chk({nm, ".index"}, int'(index6), ei);
    chk({nm, ".nofit"}, int'(nofit6), en);
  endtask

  initial begin
    int lat;
    bit bok;

    // Default table: 7,15,31,62,125,250,500,511 for entries 0..7.
    vecs[0]  = '{10'd100,  1'b0, 4, 0, 6};
    vecs[1]  = '{10'd600,  1'b0, 7, 1, 9};
    vecs[2]  = '{10'd0,    1'b0, 0, 0, 2};
    vecs[3]  = '{10'd7,    1'b0, 0, 0, 2};
    vecs[4]  = '{10'd8,    1'b0, 1, 0, 3};
    vecs[5]  = '{10'd511,  1'b0, 7, 0, 9};
    vecs[6]  = '{10'd512,  1'b0, 7, 1, 9};
    vecs[7]  = '{10'd126,  1'b0, 5, 0, 7};
    vecs[8]  = '{10'd100,  1'b1, 4, 0, 9};
    vecs[9]  = '{10'd600,  1'b1, 7, 1, 9};
    vecs[10] = '{10'd0,    1'b1, 0, 0, 9};
    vecs[11] = '{10'd500,  1'b1, 6, 0, 9};

    rst_n = 1'b0;
    start = 1'b0; mode = 1'b0; factor = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    start6 = 1'b0; mode6 = 1'b0; factor6 = '0;
    we6 = 1'b0; addr6 = '0; data6 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.index", int'(index), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.nofit", int'(nofit), 0);
    chk("rst.wr_err", int'(wr_err), 0);
    chk("rst.busy6", int'(busy6), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_req($sformatf("vec%0d", i), vecs[i].f, vecs[i].m, vecs[i].idx, vecs[i].nf, vecs[i].lat);

    // Table rewrites: entry3=120 beats 125 in best-fit, then a tie at entry5.
    wr("wr3.err", 3'd3, 10'd120, 0);
    run_req("best_wr3", 10'd100, 1'b1, 3, 0, 9);
    run_req("first_wr3", 10'd100, 1'b0, 3, 0, 5);
    wr("wr5.err", 3'd5, 10'd120, 0);
    run_req("best_tie", 10'd100, 1'b1, 3, 0, 9);

    // Write while busy is dropped.
    issue(10'd600, 1'b0);
    @(posedge clk); #1;
    wr("busy_wr.err", 3'd2, 10'd1, 1);
    @(posedge clk); #1;
    chk("busy_wr.err_width", int'(wr_err), 0);
    wait_done(lat, bok);
    chk("busy_wr.lat", lat, 6);
    chk("busy_wr.index", int'(index), 7);
    chk("busy_wr.nofit", int'(nofit), 1);
    run_req("busy_wr.verify", 10'd20, 1'b0, 2, 0, 4);

    // Restarts at scan cycle 3.
    restart_seq("rs_first", 10'd500, 1'b0, 10'd10, 1'b0, 1, 3);
    restart_seq("rs_best", 10'd10, 1'b1, 10'd100, 1'b1, 3, 9);

    // Start landing in the FIN cycle of a factor=0 request.
    issue(10'd0, 1'b0);
    @(posedge clk); #1;
    chk("fin.busy_pre", int'(busy), 1);
    chk("fin.done_pre", int'(done), 0);
    issue(10'd100, 1'b0);
    chk("fin.done", int'(done), 1);
    chk("fin.index", int'(index), 0);
    chk("fin.busy", int'(busy), 1);
    wait_done(lat, bok);
    chk("fin2.lat", lat, 5);
    chk("fin2.index", int'(index), 3);

    // Reset in the middle of a scan after a table write.
    run_req("pre_rst", 10'd600, 1'b0, 7, 1, 9);
    wr("wr4.err", 3'd4, 10'd50, 0);
    issue(10'd100, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.index", int'(index), 0);
    chk("midrst.nofit", int'(nofit), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    @(posedge clk); #1;
    chk("midrst.busy_hold", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("post_rst", 10'd100, 1'b0, 4, 0, 6);
    run_req("post_rst_best", 10'd100, 1'b1, 4, 0, 9);

    // Write and start in the same IDLE cycle: scan sees the new entry 0.
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 3'd0; tbl_data = 10'd200;
    start = 1'b1; factor = 10'd100; mode = 1'b0;
    @(posedge clk); #1;
    tbl_we = 1'b0; start = 1'b0;
    chk("wrstart.err", int'(wr_err), 0);
    wait_done(lat, bok);
    chk("wrstart.lat", lat, 2);
    chk("wrstart.index", int'(index), 0);

    // Six-entry instance: addresses 6 and 7 do not exist.
    wr6("d6.wr6", 3'd6, 9'd0, 1);
    wr6("d6.wr7", 3'd7, 9'd0, 1);
    run6("d6.miss", 9'd300, 1'b0, 5, 1, 7);
    wr6("d6.wr5", 3'd5, 9'd300, 0);
    run6("d6.fit", 9'd300, 1'b0, 5, 0, 7);
    run6("d6.best", 9'd60, 1'b1, 3, 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
